// File: rtl/keypad_pkg.sv
// Keypad scan shared types and helpers.
// Key codes, frame classification and matrix indexing.
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 5;
  localparam int KEY_CW   = $clog2(KEY_ROWS * KEY_COLS);

  typedef logic [KEY_CW-1:0] key_code_t;
  typedef logic [1:0]        key_class_t;

  localparam key_class_t KEY_CLASS_IDLE   = 2'd0;
  localparam key_class_t KEY_CLASS_SINGLE = 2'd1;
  localparam key_class_t KEY_CLASS_GHOST  = 2'd2;

  function automatic int unsigned row_col_to_code(
    input int unsigned row,
    input int unsigned col,
    input int unsigned cols
  );
    return row * cols + col;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame debouncer: accepts a scan frame once it repeats.
// Classifies the accepted frame and strobes every acceptance.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int N        = 20,
  parameter int CW       = 5,
  parameter int DEBOUNCE = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  frame,
  input  logic          frame_done,
  output logic [N-1:0]  stable,
  output key_class_t    cls,
  output logic [CW-1:0] code,
  output logic          upd
);

  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam int OW = $clog2(N + 1);

  logic [N-1:0]  prev;
  logic [SW-1:0] stab;
  logic [OW-1:0] ones;
  logic [CW-1:0] idx;
  key_class_t    ncls;
  logic          same;
  logic          reach;

  assign same  = (frame == prev);
  assign reach = frame_done && same &&
                 (stab == SW'(DEBOUNCE - 1));

  // popcount and bit index of the incoming frame
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (frame[i]) begin
        ones = ones + OW'(1);
        idx  = CW'(i);
      end
    end
    unique case (1'b1)
      (ones == '0):     ncls = KEY_CLASS_IDLE;
      (ones == OW'(1)): ncls = KEY_CLASS_SINGLE;
      default:          ncls = KEY_CLASS_GHOST;
    endcase
  end

  // run-length of identical frames; latch on reaching threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= '0;
      stab   <= '0;
      stable <= '0;
      cls    <= KEY_CLASS_IDLE;
      code   <= '0;
      upd    <= 1'b0;
    end else begin
      upd <= reach;
      if (frame_done) begin
        prev <= frame;
        if (!same)
          stab <= '0;
        else if (stab != SW'(DEBOUNCE))
          stab <= stab + SW'(1);
      end
      if (reach) begin
        stable <= frame;
        cls    <= ncls;
        if (ncls == KEY_CLASS_SINGLE)
          code <= idx;
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// Scanned matrix-keypad receiver with debounce.
// One key code per press through a valid/ack register.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 5,
  parameter int DIV      = 64,
  parameter int DEBOUNCE = 3,
  parameter int CW       = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [COLS-1:0] col_o,
  input  logic [ROWS-1:0] row_i,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ack,
  output logic            key_down,
  output logic            overflow
);

  localparam int N    = ROWS * COLS;
  localparam int IW   = $clog2(N);
  localparam int CNTW = $clog2(DIV);
  localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [CNTW-1:0] cnt;
  logic [COLW-1:0] col;
  logic [ROWS-1:0] row_s1;
  logic [ROWS-1:0] row_s2;
  logic [N-1:0]    frame;
  logic [N-1:0]    frame_nxt;
  logic            dwell_end;
  logic            frame_done;

  logic [N-1:0]    stable;
  logic [N-1:0]    last_frame;
  key_class_t      cls;
  logic [CW-1:0]   code;
  logic            upd;
  logic            press;

  assign dwell_end  = (cnt == CNTW'(DIV - 1));
  assign frame_done = dwell_end && (col == COLW'(COLS - 1));

  // dwell counter, column walk and registered column drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      col   <= '0;
      col_o <= '1;
    end else begin
      col_o <= ~(COLS'(1) << col);
      if (dwell_end) begin
        cnt <= '0;
        col <= (col == COLW'(COLS - 1)) ? '0 : col + COLW'(1);
      end else begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

  // two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_i;
      row_s2 <= row_s1;
    end
  end

  // merge the current column's rows into the frame at dwell end
  always_comb begin
    frame_nxt = frame;
    if (dwell_end) begin
      for (int r = 0; r < ROWS; r++)
        frame_nxt[IW'(row_col_to_code(r, 32'(col), COLS))] =
          ~row_s2[r];
    end
  end

  // working frame being assembled column by column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame <= '0;
    else
      frame <= frame_nxt;
  end

  keypad_debounce #(
    .N        (N),
    .CW       (CW),
    .DEBOUNCE (DEBOUNCE)
  ) u_deb (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame      (frame_nxt),
    .frame_done (frame_done),
    .stable     (stable),
    .cls        (cls),
    .code       (code),
    .upd        (upd)
  );

  // ghost frames leave last_frame untouched, so they never re-arm
  assign press = upd && (cls == KEY_CLASS_SINGLE) &&
                 (stable != last_frame);

  assign key_down = (cls == KEY_CLASS_SINGLE);

  // press memory and the valid/ack holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_frame <= '0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (upd && (cls != KEY_CLASS_GHOST))
        last_frame <= stable;
      if (press) begin
        if (!key_valid) begin
          key_code  <= code;
          key_valid <= 1'b1;
        end else if (key_ack) begin
          key_code <= code;
          overflow <= 1'b0;
        end else begin
          overflow <= 1'b1;
        end
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
        overflow  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan.
// Keypad matrix model plus frame-level reference model.
module tb_keypad_scan;
  import keypad_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int DIV  = 4;
  localparam int DEB  = 2;
  localparam int N    = ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [COLS-1:0] col_o;
  logic [ROWS-1:0] row_i;
  key_code_t       key_code;
  logic            key_valid;
  logic            key_ack = 1'b0;
  logic            key_down;
  logic            overflow;

  bit [N-1:0] pressed = '0;
  bit         chk_en = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  // resistive matrix: a pressed key pulls its row low when its column is driven
  always_comb begin
    row_i = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS+c] && !col_o[c])
          row_i[r] = 1'b0;
  end

  keypad_scan #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .DIV      (DIV),
    .DEBOUNCE (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_o     (col_o),
    .row_i     (row_i),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_down  (key_down),
    .overflow  (overflow)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: time-indexed scan, run-length debounce
  int         n = 0;
  int         run = 1;
  bit [N-1:0] wf = '0, last = '0, d1 = '0, d2 = '0;
  bit         mem_single = 1'b0;
  int         mem_code = 0;
  bit         ev_pend = 1'b0;
  key_code_t  ev_code = '0;
  bit         e_valid = 1'b0, e_ovf = 1'b0, e_kd = 1'b0;
  key_code_t  e_code = '0;
  logic [4:0] e_col = 5'h1f;
  logic [4:0] one5 = 5'b00001;

  task automatic frame_end();
    int pc, idx;
    if (wf == last) run++;
    else run = 1;
    last = wf;
    if (run == DEB + 1) begin
      pc = $countones(wf);
      idx = 0;
      for (int i = 0; i < N; i++) if (wf[i]) idx = i;
      if (pc == 1) begin
        e_kd = 1'b1;
        if (!mem_single || idx != mem_code) begin
          ev_pend = 1'b1;
          ev_code = key_code_t'(idx);
        end
        mem_single = 1'b1;
        mem_code = idx;
      end else if (pc == 0) begin
        e_kd = 1'b0;
        mem_single = 1'b0;
      end else begin
        e_kd = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    int c;
    if (!rst_n) begin
      n = 0; run = 1; wf = '0; last = '0; d1 = '0; d2 = '0;
      mem_single = 1'b0; mem_code = 0; ev_pend = 1'b0;
      e_valid = 1'b0; e_ovf = 1'b0; e_kd = 1'b0;
      e_code = '0; e_col = 5'h1f;
    end else begin
      if (ev_pend) begin
        if (!e_valid) begin
          e_valid = 1'b1; e_code = ev_code;
        end else if (key_ack) begin
          e_code = ev_code; e_ovf = 1'b0;
        end else begin
          e_ovf = 1'b1;
        end
      end else if (e_valid && key_ack) begin
        e_valid = 1'b0; e_ovf = 1'b0;
      end
      ev_pend = 1'b0;
      c = (n / DIV) % COLS;
      e_col = ~(one5 << c);
      if (n % DIV == DIV - 1) begin
        for (int r = 0; r < ROWS; r++)
          wf[r*COLS+c] = d2[r*COLS+c];
        if (c == COLS - 1) frame_end();
      end
      d2 = d1;
      d1 = pressed;
      n++;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("col_o", col_o, e_col);
      chk("key_valid", key_valid, e_valid);
      chk("key_code", key_code, e_code);
      chk("key_down", key_down, e_kd);
      chk("overflow", overflow, e_ovf);
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (key_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack1();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  bit        ok;
  int        evs;
  key_code_t lastc;

  initial begin
    cyc(3);
    chk("rst col_o", col_o, 5'h1f);
    chk("rst valid", key_valid, 0);
    chk("rst code", key_code, 0);
    chk("rst down", key_down, 0);
    chk("rst ovf", overflow, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc(1);
    chk("first col", col_o, 5'b11110);
    cyc(4);
    chk("col1", col_o, 5'b11101);
    cyc(16);
    chk("col wrap", col_o, 5'b11110);
    cyc(200);
    chk("idle valid", key_valid, 0);

    pressed[8] = 1'b1;
    wait_valid(90, ok);
    chk("t2 latency", ok, 1);
    chk("t2 code", key_code, 8);
    chk("t2 down", key_down, 1);
    cyc(500);
    chk("t2 no repeat", overflow, 0);
    ack1();
    chk("t2 ack", key_valid, 0);
    pressed[8] = 1'b0;
    cyc(100);
    chk("t2 release", key_down, 0);

    evs = 0;
    lastc = '0;
    for (int i = 0; i < 60; i++) begin
      if (i % 7 == 0) pressed[8] = ~pressed[8];
      cyc(1);
      if (key_valid) begin
        evs++; lastc = key_code; ack1();
      end
    end
    pressed[8] = 1'b1;
    for (int i = 0; i < 150; i++) begin
      cyc(1);
      if (key_valid) begin
        evs++; lastc = key_code; ack1();
      end
    end
    chk("t3 events", evs, 1);
    chk("t3 code", lastc, 8);
    pressed[8] = 1'b0;
    cyc(100);

    pressed[2] = 1'b1;
    pressed[13] = 1'b1;
    cyc(120);
    chk("t4 chord valid", key_valid, 0);
    chk("t4 chord down", key_down, 0);
    pressed[13] = 1'b0;
    wait_valid(90, ok);
    chk("t4 latency", ok, 1);
    chk("t4 code", key_code, 2);
    ack1();
    pressed[2] = 1'b0;
    cyc(100);

    pressed[8] = 1'b1;
    wait_valid(90, ok);
    chk("t5 latency", ok, 1);
    pressed[8] = 1'b0;
    cyc(100);
    pressed[19] = 1'b1;
    cyc(100);
    chk("t5 code kept", key_code, 8);
    chk("t5 ovf", overflow, 1);
    ack1();
    chk("t5 ack valid", key_valid, 0);
    chk("t5 ack ovf", overflow, 0);
    pressed[19] = 1'b0;
    cyc(100);

    pressed[8] = 1'b1;
    wait_valid(90, ok);
    chk("t6 latency", ok, 1);
    pressed[8] = 1'b0;
    cyc(100);
    pressed[19] = 1'b1;
    cyc(100);
    chk("t6 ovf set", overflow, 1);
    pressed[19] = 1'b0;
    cyc(100);
    pressed[2] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ev_pend) break;
    end
    chk("t6 aligned", ev_pend, 1);
    ack1();
    chk("t6 valid", key_valid, 1);
    chk("t6 code", key_code, 2);
    chk("t6 ovf", overflow, 0);

    cyc(7);
    #2 rst_n = 1'b0;
    #1;
    chk("async col_o", col_o, 5'h1f);
    chk("async valid", key_valid, 0);
    chk("async code", key_code, 0);
    chk("async down", key_down, 0);
    chk("async ovf", overflow, 0);
    cyc(3);
    rst_n = 1'b1;
    wait_valid(100, ok);
    chk("held after reset", ok, 1);
    chk("held code", key_code, 2);
    cyc(100);
    chk("held once", overflow, 0);
    pressed = '0;
    cyc(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
